// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite register slice.
//   AXIL_ADDR_W / AXIL_DATA_W : default address and data widths
//   RESP_OKAY                 : AXI OKAY response encoding
package axil_pkg;

  localparam int AXIL_ADDR_W = 32;
  localparam int AXIL_DATA_W = 32;

  typedef logic [1:0] axil_resp_t;

  localparam axil_resp_t RESP_OKAY = 2'b00;

endpackage

// File: rtl/axil_chan_slice.sv
// Single-entry register stage for one valid/ready channel.
// Ports:
//   clk, sync_rst_n        : clock, asynchronous active-low reset
//   s_valid/s_ready/s_data : upstream side (beat enters here)
//   m_valid/m_ready/m_data : downstream side (beat leaves here, from flops)
// Every output comes straight from a flop or from a gate of flops only.
// A beat is never accepted in the same cycle one is drained, so the stage
// moves at most one beat every two cycles.
module axil_chan_slice #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             sync_rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             rst_done_q;

  // Ready depends only on local flops; rst_done keeps ready low until the
  // first edge after reset release.
  assign s_ready = ~full_q & rst_done_q;
  assign m_valid = full_q;
  assign m_data  = data_q;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (full_q) begin
      if (m_ready) begin
        full_d = 1'b0;
      end
    end else if (s_valid && s_ready) begin
      full_d = 1'b1;
      data_d = s_data;
    end
  end

  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      full_q     <= 1'b0;
      data_q     <= '0;
      rst_done_q <= 1'b0;
    end else begin
      full_q     <= full_d;
      data_q     <= data_d;
      rst_done_q <= 1'b1;
    end
  end

endmodule

// File: rtl/axil_reg_slice_lite.sv
// AXI4-Lite register slice (light): one register stage on each of the five
// channels between the host-side slave port (s_axi_*) and the CL-side
// master port (m_axi_*).
// Ports:
//   clk, sync_rst_n          : clock, asynchronous active-low reset
//   s_axi_aw*/w*/ar*         : request channels in from the host
//   s_axi_b*/r*              : response channels out to the host
//   m_axi_aw*/w*/ar*         : request channels out to the CL
//   m_axi_b*/r*              : response channels in from the CL
// Channels are fully independent; AW and W are not paired, responses pass
// through unchanged.
module axil_reg_slice_lite
  import axil_pkg::*;
#(
  parameter int ADDR_W = AXIL_ADDR_W,
  parameter int DATA_W = AXIL_DATA_W,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              sync_rst_n,
  // slave side
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [DATA_W-1:0] s_axi_wdata,
  input  logic [STRB_W-1:0] s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  // master side
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic [STRB_W-1:0] m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  // W carries {strb, data}; R carries {resp, data}.
  logic [DATA_W+STRB_W-1:0] w_s_data, w_m_data;
  logic [DATA_W+1:0]        r_m_data, r_s_data;

  assign w_s_data                   = {s_axi_wstrb, s_axi_wdata};
  assign {m_axi_wstrb, m_axi_wdata} = w_m_data;
  assign r_m_data                   = {m_axi_rresp, m_axi_rdata};
  assign {s_axi_rresp, s_axi_rdata} = r_s_data;

  axil_chan_slice #(.WIDTH(ADDR_W)) u_aw (
    .clk(clk), .sync_rst_n(sync_rst_n),
    .s_valid(s_axi_awvalid), .s_ready(s_axi_awready), .s_data(s_axi_awaddr),
    .m_valid(m_axi_awvalid), .m_ready(m_axi_awready), .m_data(m_axi_awaddr)
  );

  axil_chan_slice #(.WIDTH(DATA_W+STRB_W)) u_w (
    .clk(clk), .sync_rst_n(sync_rst_n),
    .s_valid(s_axi_wvalid), .s_ready(s_axi_wready), .s_data(w_s_data),
    .m_valid(m_axi_wvalid), .m_ready(m_axi_wready), .m_data(w_m_data)
  );

  axil_chan_slice #(.WIDTH(2)) u_b (
    .clk(clk), .sync_rst_n(sync_rst_n),
    .s_valid(m_axi_bvalid), .s_ready(m_axi_bready), .s_data(m_axi_bresp),
    .m_valid(s_axi_bvalid), .m_ready(s_axi_bready), .m_data(s_axi_bresp)
  );

  axil_chan_slice #(.WIDTH(ADDR_W)) u_ar (
    .clk(clk), .sync_rst_n(sync_rst_n),
    .s_valid(s_axi_arvalid), .s_ready(s_axi_arready), .s_data(s_axi_araddr),
    .m_valid(m_axi_arvalid), .m_ready(m_axi_arready), .m_data(m_axi_araddr)
  );

  axil_chan_slice #(.WIDTH(DATA_W+2)) u_r (
    .clk(clk), .sync_rst_n(sync_rst_n),
    .s_valid(m_axi_rvalid), .s_ready(m_axi_rready), .s_data(r_m_data),
    .m_valid(s_axi_rvalid), .m_ready(s_axi_rready), .m_data(r_s_data)
  );

endmodule

// File: tb/tb_axil_reg_slice_lite.sv
module tb_axil_reg_slice_lite;
  import axil_pkg::*;

  localparam int CH_AW = 0, CH_W = 1, CH_B = 2, CH_AR = 3, CH_R = 4;

  logic        clk = 1'b0;
  logic        sync_rst_n;
  logic [31:0] s_axi_awaddr;  logic s_axi_awvalid, s_axi_awready;
  logic [31:0] s_axi_wdata;   logic [3:0] s_axi_wstrb; logic s_axi_wvalid, s_axi_wready;
  logic [1:0]  s_axi_bresp;   logic s_axi_bvalid, s_axi_bready;
  logic [31:0] s_axi_araddr;  logic s_axi_arvalid, s_axi_arready;
  logic [31:0] s_axi_rdata;   logic [1:0] s_axi_rresp; logic s_axi_rvalid, s_axi_rready;
  logic [31:0] m_axi_awaddr;  logic m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_wdata;   logic [3:0] m_axi_wstrb; logic m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp;   logic m_axi_bvalid, m_axi_bready;
  logic [31:0] m_axi_araddr;  logic m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_rdata;   logic [1:0] m_axi_rresp; logic m_axi_rvalid, m_axi_rready;

  axil_reg_slice_lite dut (
    .clk(clk), .sync_rst_n(sync_rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard queues: expected downstream payload per channel, {aux, data}.
  logic [35:0] q_aw[$], q_w[$], q_b[$], q_ar[$], q_r[$];

  typedef struct {
    int          ch;
    logic [31:0] data;
    logic [3:0]  aux;
    logic [31:0] exp_data;
    logic [3:0]  exp_aux;
  } vec_t;

  vec_t vecs[10];

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic sb_pop(input int ch, input logic [35:0] act);
    logic [35:0] e;
    bit          ok;
    string       nm;
    ok = 1'b1;
    e  = '0;
    case (ch)
      CH_AW: begin nm = "sb_aw"; if (q_aw.size() > 0) e = q_aw.pop_front(); else ok = 1'b0; end
      CH_W:  begin nm = "sb_w";  if (q_w.size()  > 0) e = q_w.pop_front();  else ok = 1'b0; end
      CH_B:  begin nm = "sb_b";  if (q_b.size()  > 0) e = q_b.pop_front();  else ok = 1'b0; end
      CH_AR: begin nm = "sb_ar"; if (q_ar.size() > 0) e = q_ar.pop_front(); else ok = 1'b0; end
      default: begin nm = "sb_r"; if (q_r.size() > 0) e = q_r.pop_front(); else ok = 1'b0; end
    endcase
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s unexpected beat actual=%0h required=none", nm, act);
    end else begin
      cmp(nm, {28'h0, act}, {28'h0, e});
    end
  endtask

  function automatic logic up_ready(input int ch);
    case (ch)
      CH_AW:   return s_axi_awready;
      CH_W:    return s_axi_wready;
      CH_B:    return m_axi_bready;
      CH_AR:   return s_axi_arready;
      default: return m_axi_rready;
    endcase
  endfunction

  // Drive one beat on the upstream side of a channel, hold until accepted.
  task automatic drive_beat(input int ch, input logic [31:0] d, input logic [3:0] a);
    int n;
    @(posedge clk); #1;
    case (ch)
      CH_AW:   begin s_axi_awaddr = d; s_axi_awvalid = 1'b1; end
      CH_W:    begin s_axi_wdata = d; s_axi_wstrb = a; s_axi_wvalid = 1'b1; end
      CH_B:    begin m_axi_bresp = a[1:0]; m_axi_bvalid = 1'b1; end
      CH_AR:   begin s_axi_araddr = d; s_axi_arvalid = 1'b1; end
      default: begin m_axi_rdata = d; m_axi_rresp = a[1:0]; m_axi_rvalid = 1'b1; end
    endcase
    n = 0;
    @(negedge clk);
    while (!up_ready(ch) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout ch=%0d actual=no_ready required=ready", ch);
    end
    @(posedge clk); #1;
    case (ch)
      CH_AW:   s_axi_awvalid = 1'b0;
      CH_W:    s_axi_wvalid  = 1'b0;
      CH_B:    m_axi_bvalid  = 1'b0;
      CH_AR:   s_axi_arvalid = 1'b0;
      default: m_axi_rvalid  = 1'b0;
    endcase
  endtask

  task automatic push_exp(input int ch, input logic [35:0] e);
    case (ch)
      CH_AW:   q_aw.push_back(e);
      CH_W:    q_w.push_back(e);
      CH_B:    q_b.push_back(e);
      CH_AR:   q_ar.push_back(e);
      default: q_r.push_back(e);
    endcase
  endtask

  // Downstream monitor: a beat whose valid and ready are both high at the
  // falling edge transfers on the following rising edge.
  always @(negedge clk) begin
    if (sync_rst_n === 1'b1) begin
      if (m_axi_awvalid && m_axi_awready) sb_pop(CH_AW, {4'h0, m_axi_awaddr});
      if (m_axi_wvalid  && m_axi_wready)  sb_pop(CH_W,  {m_axi_wstrb, m_axi_wdata});
      if (s_axi_bvalid  && s_axi_bready)  sb_pop(CH_B,  {2'b00, s_axi_bresp, 32'h0});
      if (m_axi_arvalid && m_axi_arready) sb_pop(CH_AR, {4'h0, m_axi_araddr});
      if (s_axi_rvalid  && s_axi_rready)  sb_pop(CH_R,  {2'b00, s_axi_rresp, s_axi_rdata});
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] pat;
    logic       rdy;
    int         idx;

    vecs[0] = '{CH_AW, 32'h0000_0010, 4'h0, 32'h0000_0010, 4'h0};
    vecs[1] = '{CH_W,  32'hCAFE_F00D, 4'h3, 32'hCAFE_F00D, 4'h3};
    vecs[2] = '{CH_B,  32'h0,         4'h2, 32'h0,         4'h2};
    vecs[3] = '{CH_AR, 32'hFFFF_FFFC, 4'h0, 32'hFFFF_FFFC, 4'h0};
    vecs[4] = '{CH_R,  32'h1234_5678, 4'h3, 32'h1234_5678, 4'h3};
    vecs[5] = '{CH_W,  32'hFFFF_FFFF, 4'hF, 32'hFFFF_FFFF, 4'hF};
    vecs[6] = '{CH_AW, 32'h8000_0000, 4'h0, 32'h8000_0000, 4'h0};
    vecs[7] = '{CH_R,  32'h0000_0000, 4'h1, 32'h0000_0000, 4'h1};
    vecs[8] = '{CH_B,  32'h0,         4'h1, 32'h0,         4'h1};
    vecs[9] = '{CH_AR, 32'h0000_0000, 4'h0, 32'h0000_0000, 4'h0};

    sync_rst_n    = 1'b0;
    s_axi_awaddr  = 32'h5555_5555; s_axi_awvalid = 1'b1;
    s_axi_wdata   = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0;
    s_axi_araddr  = '0; s_axi_arvalid = 1'b0;
    s_axi_bready  = 1'b1; s_axi_rready = 1'b1;
    m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_arready = 1'b1;
    m_axi_bresp   = '0; m_axi_bvalid = 1'b0;
    m_axi_rdata   = '0; m_axi_rresp = '0; m_axi_rvalid = 1'b0;

    // Reset: nothing valid, nothing ready, payload cleared.
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, s_axi_bvalid, s_axi_rvalid}, 0);
    cmp("rst_readies", {s_axi_awready, s_axi_wready, s_axi_arready, m_axi_bready, m_axi_rready}, 0);
    cmp("rst_awaddr", m_axi_awaddr, 0);
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    sync_rst_n = 1'b1;
    @(negedge clk);
    cmp("rdy_before_edge", {s_axi_awready, s_axi_wready, s_axi_arready, m_axi_bready, m_axi_rready}, 0);
    @(negedge clk);
    cmp("rdy_after_edge", {s_axi_awready, s_axi_wready, s_axi_arready, m_axi_bready, m_axi_rready}, 5'h1F);

    // Single write: AW and W together, then B response.
    @(posedge clk); #1;
    s_axi_awaddr = 32'h0000_0600; s_axi_awvalid = 1'b1;
    s_axi_wdata  = 32'h0000_0001; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    push_exp(CH_AW, {4'h0, 32'h0000_0600});
    push_exp(CH_W,  {4'hF, 32'h0000_0001});
    @(negedge clk);
    cmp("wr_awvalid_lat0", {m_axi_awvalid, m_axi_wvalid}, 2'b00);
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    @(negedge clk);
    cmp("wr_valid_lat1", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
    cmp("wr_full_ready", {s_axi_awready, s_axi_wready}, 2'b00);
    @(posedge clk); #1;
    m_axi_bresp = RESP_OKAY; m_axi_bvalid = 1'b1;
    push_exp(CH_B, {2'b00, RESP_OKAY, 32'h0});
    @(posedge clk); #1;
    m_axi_bvalid = 1'b0;
    @(negedge clk);
    cmp("wr_bvalid", {s_axi_bvalid, s_axi_bresp}, {1'b1, RESP_OKAY});

    // Single read.
    @(posedge clk); #1;
    s_axi_araddr = 32'h0000_0700; s_axi_arvalid = 1'b1;
    push_exp(CH_AR, {4'h0, 32'h0000_0700});
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    @(negedge clk);
    cmp("rd_araddr", {m_axi_arvalid, m_axi_araddr}, {1'b1, 32'h0000_0700});
    @(posedge clk); #1;
    m_axi_rdata = 32'hDEAD_BEEF; m_axi_rresp = RESP_OKAY; m_axi_rvalid = 1'b1;
    push_exp(CH_R, {2'b00, RESP_OKAY, 32'hDEAD_BEEF});
    @(posedge clk); #1;
    m_axi_rvalid = 1'b0;
    @(negedge clk);
    cmp("rd_rdata", {s_axi_rvalid, s_axi_rdata}, {1'b1, 32'hDEAD_BEEF});

    // Table-driven beats across all channels.
    for (int i = 0; i < 10; i++) begin
      push_exp(vecs[i].ch, {vecs[i].exp_aux, vecs[i].exp_data});
      drive_beat(vecs[i].ch, vecs[i].data, vecs[i].aux);
    end
    repeat (3) @(posedge clk);

    // Backpressure on AR, with upstream activity while full.
    #1;
    m_axi_arready = 1'b0;
    push_exp(CH_AR, {4'h0, 32'h0000_1234});
    drive_beat(CH_AR, 32'h0000_1234, 4'h0);
    s_axi_araddr = 32'h0000_0BAD; s_axi_arvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      cmp("bp_hold", {m_axi_arvalid, s_axi_arready, m_axi_araddr}, {1'b1, 1'b0, 32'h0000_1234});
    end
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    m_axi_arready = 1'b1;
    @(negedge clk);
    cmp("bp_rdy_same", s_axi_arready, 1'b0);
    @(negedge clk);
    cmp("bp_rdy_next", {s_axi_arready, m_axi_arvalid}, 2'b10);

    // W three cycles ahead of AW.
    @(posedge clk); #1;
    s_axi_wdata = 32'hA5A5_0003; s_axi_wstrb = 4'h5; s_axi_wvalid = 1'b1;
    push_exp(CH_W, {4'h5, 32'hA5A5_0003});
    @(posedge clk); #1;
    s_axi_wvalid = 1'b0;
    @(negedge clk);
    cmp("skew_w_only", {m_axi_wvalid, m_axi_awvalid}, 2'b10);
    @(posedge clk); #1;
    @(posedge clk); #1;
    s_axi_awaddr = 32'h0000_0A00; s_axi_awvalid = 1'b1;
    push_exp(CH_AW, {4'h0, 32'h0000_0A00});
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    @(negedge clk);
    cmp("skew_aw_only", {m_axi_wvalid, m_axi_awvalid}, 2'b01);

    // Throughput: continuous arvalid, one handshake every two cycles.
    @(posedge clk); #1;
    s_axi_araddr = 32'h0; s_axi_arvalid = 1'b1;
    push_exp(CH_AR, 36'h0); push_exp(CH_AR, 36'h4); push_exp(CH_AR, 36'h8);
    idx = 0; pat = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      rdy = s_axi_arready;
      pat = {pat[3:0], rdy};
      @(posedge clk); #1;
      if (rdy) begin
        idx++;
        if (idx == 3) s_axi_arvalid = 1'b0;
        else s_axi_araddr = 32'(idx * 4);
      end
    end
    cmp("tput_pattern", pat, 5'b10101);
    repeat (3) @(posedge clk);

    // Reset while a beat is held: valid drops at once, beat not replayed.
    #1;
    m_axi_arready = 1'b0;
    drive_beat(CH_AR, 32'h0000_0CCC, 4'h0);
    @(negedge clk);
    cmp("mid_held", m_axi_arvalid, 1'b1);
    @(posedge clk); #1;
    sync_rst_n = 1'b0;
    #1;
    cmp("mid_async_drop", {m_axi_arvalid, s_axi_arready}, 2'b00);
    @(posedge clk); #1;
    sync_rst_n = 1'b1;
    m_axi_arready = 1'b1;
    repeat (3) @(negedge clk);
    cmp("mid_no_replay", {m_axi_arvalid, s_axi_arready}, 2'b01);

    repeat (3) @(posedge clk);
    cmp("sb_drained", q_aw.size() + q_w.size() + q_b.size() + q_ar.size() + q_r.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
